// File: rtl/ped_request_unit.sv
// Pedestrian request front end: synchronise, debounce, latch one request until ped_green acknowledges, then hold off.
// Optional PED_REQ_COUNT_EN adds a saturating 16-bit count of requests presented to the controller.
module ped_request_unit #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLDOFF_CYCLES  = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_raw,
  input  logic        ped_green,
  output logic        ped_button_pressed,
  output logic        wait_lamp,
  output logic [3:0]  debug_state
`ifdef PED_REQ_COUNT_EN
  ,
  output logic [15:0] req_count
`endif
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int HO_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQUESTED = 2'd1,
    SERVING   = 2'd2,
    HOLDOFF   = 2'd3
  } state_t;

  logic            s1, s2;
  logic            btn_clean, clean_q;
  logic [DB_W-1:0] db_cnt;
  logic [HO_W-1:0] ho_cnt;
  logic            pending;
  logic            press;
  state_t          state, next_state;
  logic            ho_clr, pend_set, pend_clr;

  // NOTE: all clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_clean <= 1'b0;
      db_cnt    <= '0;
    end else if (s2 == btn_clean) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      btn_clean <= s2;
      db_cnt    <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) clean_q <= 1'b0;
    else     clean_q <= btn_clean;
  end

  assign press = btn_clean & ~clean_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    ho_clr     = 1'b0;
    pend_set   = 1'b0;
    pend_clr   = 1'b0;
    unique case (state)
      IDLE: begin
        if (ped_green)  next_state = SERVING;
        else if (press) next_state = REQUESTED;
      end
      REQUESTED: begin
        if (ped_green) next_state = SERVING;
      end
      SERVING: begin
        if (!ped_green) begin
          next_state = HOLDOFF;
          ho_clr     = 1'b1;
          pend_clr   = 1'b1;
        end
      end
      HOLDOFF: begin
        if (ped_green) begin
          next_state = SERVING;
          pend_clr   = 1'b1;
        end else if (ho_cnt == HO_LAST) begin
          next_state = (pending | press) ? REQUESTED : IDLE;
          pend_clr   = 1'b1;
        end else begin
          pend_set = press;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ho_cnt  <= '0;
      pending <= 1'b0;
    end else begin
      if (ho_clr)
        ho_cnt <= '0;
      else if (state == HOLDOFF && ho_cnt != HO_LAST)
        ho_cnt <= ho_cnt + HO_W'(1);

      if (pend_clr)      pending <= 1'b0;
      else if (pend_set) pending <= 1'b1;
    end
  end

  assign ped_button_pressed = (state == REQUESTED);
  assign wait_lamp          = (state == REQUESTED);
  assign debug_state        = {2'b00, state};

`ifdef PED_REQ_COUNT_EN
  logic enter_req;
  assign enter_req = (next_state == REQUESTED) && (state != REQUESTED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      req_count <= 16'd0;
    else if (enter_req && req_count != 16'hFFFF)
      req_count <= req_count + 16'd1;
  end
`endif

endmodule
